// File: rtl/countdown_timer_if.sv
// Control/preset/display bundle for countdown_timer.
interface countdown_timer_if;
    logic       load_pulse;
    logic       start_pulse;
    logic       stop_pulse;
    logic [3:0] preset_min;
    logic [2:0] preset_sec_tens;
    logic [3:0] preset_sec_ones;
    logic [3:0] preset_tenths;
    logic [3:0] minutes;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] tenths;
    logic       running;
    logic       expired;
    logic       alarm;

    modport master (
        output load_pulse, start_pulse, stop_pulse,
        output preset_min, preset_sec_tens, preset_sec_ones, preset_tenths,
        input  minutes, sec_tens, sec_ones, tenths, running, expired, alarm
    );

    modport slave (
        input  load_pulse, start_pulse, stop_pulse,
        input  preset_min, preset_sec_tens, preset_sec_ones, preset_tenths,
        output minutes, sec_tens, sec_ones, tenths, running, expired, alarm
    );
endinterface

// File: rtl/countdown_timer.sv
// BCD M:SS.T countdown timer with IDLE/RUN/PAUSE/DONE control.
// Optional alarm blinking in DONE is enabled by defining COUNTDOWN_ALARM_BLINK_EN.
module countdown_timer #(
    parameter int unsigned TICKS_PER_TENTH = 5000000,
    parameter int unsigned BLINK_TENTHS    = 5
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    countdown_timer_if.slave tmr
);
    localparam int unsigned PreW = (TICKS_PER_TENTH > 1) ? $clog2(TICKS_PER_TENTH) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(TICKS_PER_TENTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t          state, stateNxt;
    logic [3:0]      minReg, minNxt, decMin, clMin;
    logic [2:0]      secTensReg, secTensNxt, decSecTens, clSecTens;
    logic [3:0]      secOnesReg, secOnesNxt, decSecOnes, clSecOnes;
    logic [3:0]      tenthsReg, tenthsNxt, decTenths, clTenths;
    logic [PreW-1:0] preCnt, preNxt;
    logic            runningReg, expiredReg;
    logic            firstEdge, prevLoad, prevStart, prevStop;
    logic            loadP, startP, stopP, doLoad, doStart, doStop;
    logic            isZero, decZero, tick;

    // A pulse already high during reset (sampled by the unreset flops) is dropped on the first edge.
    always_ff @(posedge CLOCK_50) begin
        prevLoad  <= tmr.load_pulse;
        prevStart <= tmr.start_pulse;
        prevStop  <= tmr.stop_pulse;
    end

    assign loadP   = tmr.load_pulse  & ~(firstEdge & prevLoad);
    assign startP  = tmr.start_pulse & ~(firstEdge & prevStart);
    assign stopP   = tmr.stop_pulse  & ~(firstEdge & prevStop);
    assign doStop  = stopP;
    assign doLoad  = loadP & ~stopP;
    assign doStart = startP & ~stopP & ~loadP;

    assign clMin     = (tmr.preset_min      > 4'd9) ? 4'd9 : tmr.preset_min;
    assign clSecTens = (tmr.preset_sec_tens > 3'd5) ? 3'd5 : tmr.preset_sec_tens;
    assign clSecOnes = (tmr.preset_sec_ones > 4'd9) ? 4'd9 : tmr.preset_sec_ones;
    assign clTenths  = (tmr.preset_tenths   > 4'd9) ? 4'd9 : tmr.preset_tenths;

    assign isZero  = (minReg == '0) && (secTensReg == '0) && (secOnesReg == '0) && (tenthsReg == '0);
    assign decZero = (decMin == '0) && (decSecTens == '0) && (decSecOnes == '0) && (decTenths == '0);
    assign tick    = (preCnt == PreLast);

    always_comb begin
        decMin     = minReg;
        decSecTens = secTensReg;
        decSecOnes = secOnesReg;
        decTenths  = tenthsReg;
        if (tenthsReg != '0) begin
            decTenths = tenthsReg - 4'd1;
        end else begin
            decTenths = 4'd9;
            if (secOnesReg != '0) begin
                decSecOnes = secOnesReg - 4'd1;
            end else begin
                decSecOnes = 4'd9;
                if (secTensReg != '0) begin
                    decSecTens = secTensReg - 3'd1;
                end else begin
                    decSecTens = 3'd5;
                    decMin     = minReg - 4'd1;
                end
            end
        end
    end

    always_comb begin
        stateNxt   = state;
        minNxt     = minReg;
        secTensNxt = secTensReg;
        secOnesNxt = secOnesReg;
        tenthsNxt  = tenthsReg;
        preNxt     = preCnt;
        unique case (state)
            IDLE: begin
                if (doStop) begin
                    {minNxt, secTensNxt, secOnesNxt, tenthsNxt} = '0;
                end else if (doLoad) begin
                    {minNxt, secTensNxt, secOnesNxt, tenthsNxt} = {clMin, clSecTens, clSecOnes, clTenths};
                end else if (doStart && !isZero) begin
                    stateNxt = RUN;
                    preNxt   = '0;
                end
            end
            RUN: begin
                if (doStop) begin
                    stateNxt = PAUSE;
                end else if (tick) begin
                    preNxt = '0;
                    if (!isZero) begin
                        {minNxt, secTensNxt, secOnesNxt, tenthsNxt} = {decMin, decSecTens, decSecOnes, decTenths};
                    end
                    if (isZero || decZero) stateNxt = DONE;
                end else begin
                    preNxt = preCnt + 1'b1;
                end
            end
            PAUSE: begin
                if (doStop) begin
                    stateNxt = IDLE;
                    {minNxt, secTensNxt, secOnesNxt, tenthsNxt} = '0;
                end else if (doLoad) begin
                    stateNxt = IDLE;
                    {minNxt, secTensNxt, secOnesNxt, tenthsNxt} = {clMin, clSecTens, clSecOnes, clTenths};
                end else if (doStart) begin
                    stateNxt = RUN;
                    preNxt   = '0;
                end
            end
            DONE: begin
                if (doStop) begin
                    stateNxt = IDLE;
                end else if (doLoad) begin
                    stateNxt = IDLE;
                    {minNxt, secTensNxt, secOnesNxt, tenthsNxt} = {clMin, clSecTens, clSecOnes, clTenths};
                end
`ifdef COUNTDOWN_ALARM_BLINK_EN
                else begin
                    preNxt = tick ? '0 : preCnt + 1'b1;
                end
`endif
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            minReg     <= '0;
            secTensReg <= '0;
            secOnesReg <= '0;
            tenthsReg  <= '0;
            preCnt     <= '0;
            runningReg <= 1'b0;
            expiredReg <= 1'b0;
            firstEdge  <= 1'b1;
        end else begin
            state      <= stateNxt;
            minReg     <= minNxt;
            secTensReg <= secTensNxt;
            secOnesReg <= secOnesNxt;
            tenthsReg  <= tenthsNxt;
            preCnt     <= preNxt;
            runningReg <= (stateNxt == RUN);
            expiredReg <= (stateNxt == DONE);
            firstEdge  <= 1'b0;
        end
    end

`ifdef COUNTDOWN_ALARM_BLINK_EN
    localparam int unsigned BlinkW = (BLINK_TENTHS > 1) ? $clog2(BLINK_TENTHS) : 1;
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_TENTHS - 1);

    logic [BlinkW-1:0] blinkCnt, blinkNxt;
    logic              alarmReg, alarmNxt;

    always_comb begin
        blinkNxt = blinkCnt;
        alarmNxt = alarmReg;
        if (stateNxt != DONE) begin
            blinkNxt = '0;
            alarmNxt = 1'b0;
        end else if (state != DONE) begin
            blinkNxt = '0;
            alarmNxt = 1'b1;
        end else if (tick) begin
            if (blinkCnt == BlinkLast) begin
                blinkNxt = '0;
                alarmNxt = ~alarmReg;
            end else begin
                blinkNxt = blinkCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            blinkCnt <= '0;
            alarmReg <= 1'b0;
        end else begin
            blinkCnt <= blinkNxt;
            alarmReg <= alarmNxt;
        end
    end

    assign tmr.alarm = alarmReg;
`else
    assign tmr.alarm = expiredReg;
`endif

    assign tmr.minutes  = minReg;
    assign tmr.sec_tens = secTensReg;
    assign tmr.sec_ones = secOnesReg;
    assign tmr.tenths   = tenthsReg;
    assign tmr.running  = runningReg;
    assign tmr.expired  = expiredReg;
endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer at TICKS_PER_TENTH=4, BLINK_TENTHS=5.
// Blink expectations follow COUNTDOWN_ALARM_BLINK_EN.
module tb_countdown_timer;
    localparam logic [2:0] P_NONE  = 3'b000;
    localparam logic [2:0] P_START = 3'b001;
    localparam logic [2:0] P_LOAD  = 3'b010;
    localparam logic [2:0] P_STOP  = 3'b100;
`ifdef COUNTDOWN_ALARM_BLINK_EN
    localparam logic BLINKS = 1'b1;
`else
    localparam logic BLINKS = 1'b0;
`endif

    // pul = {stop, load, start}; want = {min, secTens, secOnes, tenths, running, expired, alarm}
    typedef struct {
        string       tag;
        logic [2:0]  pul;
        int unsigned cycles;
        logic [17:0] want;
    } step_t;

    logic        CLOCK_50 = 1'b0;
    logic        resetn;
    int          checks = 0;
    int          errors = 0;
    step_t       sbQ[$];
    logic [17:0] obs;

    countdown_timer_if bus ();

    countdown_timer #(.TICKS_PER_TENTH(4), .BLINK_TENTHS(5)) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .tmr      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    assign obs = {bus.minutes, bus.sec_tens, bus.sec_ones, bus.tenths,
                  bus.running, bus.expired, bus.alarm};

    function automatic void push(input string tag, input logic [2:0] pul, input int unsigned cyc,
                                 input int m, input int st, input int so, input int t,
                                 input logic [2:0] flags);
        step_t s;
        s.tag    = tag;
        s.pul    = pul;
        s.cycles = cyc;
        s.want   = {4'(m), 3'(st), 4'(so), 4'(t), flags};
        sbQ.push_back(s);
    endfunction

    task automatic setPreset(input int m, input int st, input int so, input int t);
        bus.preset_min      = 4'(m);
        bus.preset_sec_tens = 3'(st);
        bus.preset_sec_ones = 4'(so);
        bus.preset_tenths   = 4'(t);
    endtask

    task automatic test_reset;
        step_t s;
        repeat (2) @(negedge CLOCK_50);
        push("rstHeld", P_NONE, 0, 0, 0, 0, 0, 3'b000);
        s = sbQ.pop_front();
        checks++;
        if (obs !== s.want) begin errors++; $display("FAIL %s got %h want %h", s.tag, obs, s.want); end
        resetn = 1'b1;
        push("rstRel", P_NONE, 2, 0, 0, 0, 0, 3'b000);
        while (sbQ.size() != 0) begin
            s = sbQ.pop_front();
            {bus.stop_pulse, bus.load_pulse, bus.start_pulse} = s.pul;
            @(negedge CLOCK_50);
            {bus.stop_pulse, bus.load_pulse, bus.start_pulse} = P_NONE;
            repeat (s.cycles - 1) @(negedge CLOCK_50);
            checks++;
            if (obs !== s.want) begin errors++; $display("FAIL %s got %h want %h", s.tag, obs, s.want); end
        end
    endtask

    task automatic test_load;
        step_t s;
        setPreset(0, 0, 0, 3);
        push("load003",  P_LOAD,  1, 0, 0, 0, 3, 3'b000);
        push("start003", P_START, 1, 0, 0, 0, 3, 3'b100);
        push("pre3",     P_NONE,  3, 0, 0, 0, 3, 3'b100);
        push("tick002",  P_NONE,  1, 0, 0, 0, 2, 3'b100);
        push("tick001",  P_NONE,  4, 0, 0, 0, 1, 3'b100);
        push("pre3b",    P_NONE,  3, 0, 0, 0, 1, 3'b100);
        push("done000",  P_NONE,  1, 0, 0, 0, 0, 3'b011);
        while (sbQ.size() != 0) begin
            s = sbQ.pop_front();
            {bus.stop_pulse, bus.load_pulse, bus.start_pulse} = s.pul;
            @(negedge CLOCK_50);
            {bus.stop_pulse, bus.load_pulse, bus.start_pulse} = P_NONE;
            repeat (s.cycles - 1) @(negedge CLOCK_50);
            checks++;
            if (obs !== s.want) begin errors++; $display("FAIL %s got %h want %h", s.tag, obs, s.want); end
        end
    endtask

    // Entered right after the DONE entry edge left by test_load.
    task automatic test_blink;
        step_t s;
        push("blinkHigh",  P_NONE,  19, 0, 0, 0, 0, 3'b011);
        push("blinkTog",   P_NONE,   1, 0, 0, 0, 0, {2'b01, ~BLINKS});
        push("blinkBack",  P_NONE,  20, 0, 0, 0, 0, 3'b011);
        push("doneStart",  P_START,  1, 0, 0, 0, 0, 3'b011);
        push("doneStop",   P_STOP,   1, 0, 0, 0, 0, 3'b000);
        while (sbQ.size() != 0) begin
            s = sbQ.pop_front();
            {bus.stop_pulse, bus.load_pulse, bus.start_pulse} = s.pul;
            @(negedge CLOCK_50);
            {bus.stop_pulse, bus.load_pulse, bus.start_pulse} = P_NONE;
            repeat (s.cycles - 1) @(negedge CLOCK_50);
            checks++;
            if (obs !== s.want) begin errors++; $display("FAIL %s got %h want %h", s.tag, obs, s.want); end
        end
    endtask

    task automatic test_borrow;
        step_t s;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                setPreset(1, 0, 0, 0);
                push("load100",  P_LOAD,  1, 1, 0, 0, 0, 3'b000);
                push("run100",   P_START, 1, 1, 0, 0, 0, 3'b100);
                push("borrow599", P_NONE, 4, 0, 5, 9, 9, 3'b100);
                push("pause599", P_STOP,  1, 0, 5, 9, 9, 3'b000);
            end else begin
                setPreset(0, 1, 0, 0);
                push("load010",  P_LOAD,  1, 0, 1, 0, 0, 3'b000);
                push("run010",   P_START, 1, 0, 1, 0, 0, 3'b100);
                push("borrow099", P_NONE, 4, 0, 0, 9, 9, 3'b100);
                push("pause099", P_STOP,  1, 0, 0, 9, 9, 3'b000);
            end
            push("pauseClr", P_STOP, 1, 0, 0, 0, 0, 3'b000);
            while (sbQ.size() != 0) begin
                s = sbQ.pop_front();
                {bus.stop_pulse, bus.load_pulse, bus.start_pulse} = s.pul;
                @(negedge CLOCK_50);
                {bus.stop_pulse, bus.load_pulse, bus.start_pulse} = P_NONE;
                repeat (s.cycles - 1) @(negedge CLOCK_50);
                checks++;
                if (obs !== s.want) begin errors++; $display("FAIL %s got %h want %h", s.tag, obs, s.want); end
            end
        end
    endtask

    task automatic test_pause_resume;
        step_t s;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                setPreset(0, 0, 5, 0);
                push("load050",   P_LOAD,  1, 0, 0, 5, 0, 3'b000);
                push("run050",    P_START, 1, 0, 0, 5, 0, 3'b100);
                push("twoTicks",  P_NONE,  8, 0, 0, 4, 8, 3'b100);
                push("paused",    P_STOP,  1, 0, 0, 4, 8, 3'b000);
                push("pauseHold", P_NONE,  6, 0, 0, 4, 8, 3'b000);
                push("resume",    P_START, 1, 0, 0, 4, 8, 3'b100);
                push("resPre3",   P_NONE,  3, 0, 0, 4, 8, 3'b100);
                push("resTick",   P_NONE,  1, 0, 0, 4, 7, 3'b100);
                push("paused2",   P_STOP,  1, 0, 0, 4, 7, 3'b000);
            end else begin
                setPreset(0, 0, 1, 5);
                push("pauseLoad", P_LOAD,  1, 0, 0, 1, 5, 3'b000);
                push("idleClr",   P_STOP,  1, 0, 0, 0, 0, 3'b000);
            end
            while (sbQ.size() != 0) begin
                s = sbQ.pop_front();
                {bus.stop_pulse, bus.load_pulse, bus.start_pulse} = s.pul;
                @(negedge CLOCK_50);
                {bus.stop_pulse, bus.load_pulse, bus.start_pulse} = P_NONE;
                repeat (s.cycles - 1) @(negedge CLOCK_50);
                checks++;
                if (obs !== s.want) begin errors++; $display("FAIL %s got %h want %h", s.tag, obs, s.want); end
            end
        end
    endtask

    task automatic test_clamp_priority;
        step_t s;
        setPreset(15, 7, 15, 15);
        push("clampLoad",  P_LOAD,           1, 9, 5, 9, 9, 3'b000);
        push("loadOverSt", P_LOAD | P_START, 1, 9, 5, 9, 9, 3'b000);
        push("run959",     P_START,          1, 9, 5, 9, 9, 3'b100);
        push("tick958",    P_NONE,           4, 9, 5, 9, 8, 3'b100);
        push("allInRun",   3'b111,           1, 9, 5, 9, 8, 3'b000);
        push("stopOverLd", P_LOAD | P_STOP,  1, 0, 0, 0, 0, 3'b000);
        while (sbQ.size() != 0) begin
            s = sbQ.pop_front();
            {bus.stop_pulse, bus.load_pulse, bus.start_pulse} = s.pul;
            @(negedge CLOCK_50);
            {bus.stop_pulse, bus.load_pulse, bus.start_pulse} = P_NONE;
            repeat (s.cycles - 1) @(negedge CLOCK_50);
            checks++;
            if (obs !== s.want) begin errors++; $display("FAIL %s got %h want %h", s.tag, obs, s.want); end
        end
    endtask

    task automatic test_done_load;
        step_t s;
        setPreset(0, 0, 0, 1);
        push("load001",  P_LOAD,  1, 0, 0, 0, 1, 3'b000);
        push("run001",   P_START, 1, 0, 0, 0, 1, 3'b100);
        push("pre3c",    P_NONE,  3, 0, 0, 0, 1, 3'b100);
        push("done2",    P_NONE,  1, 0, 0, 0, 0, 3'b011);
        push("doneLoad", P_LOAD,  1, 0, 0, 0, 1, 3'b000);
        push("clr2",     P_STOP,  1, 0, 0, 0, 0, 3'b000);
        while (sbQ.size() != 0) begin
            s = sbQ.pop_front();
            {bus.stop_pulse, bus.load_pulse, bus.start_pulse} = s.pul;
            @(negedge CLOCK_50);
            {bus.stop_pulse, bus.load_pulse, bus.start_pulse} = P_NONE;
            repeat (s.cycles - 1) @(negedge CLOCK_50);
            checks++;
            if (obs !== s.want) begin errors++; $display("FAIL %s got %h want %h", s.tag, obs, s.want); end
        end
    endtask

    task automatic test_reset_midrun;
        step_t s;
        setPreset(0, 3, 0, 0);
        push("load300", P_LOAD,  1, 0, 3, 0, 0, 3'b000);
        push("run300",  P_START, 1, 0, 3, 0, 0, 3'b100);
        push("mid",     P_NONE,  2, 0, 3, 0, 0, 3'b100);
        while (sbQ.size() != 0) begin
            s = sbQ.pop_front();
            {bus.stop_pulse, bus.load_pulse, bus.start_pulse} = s.pul;
            @(negedge CLOCK_50);
            {bus.stop_pulse, bus.load_pulse, bus.start_pulse} = P_NONE;
            repeat (s.cycles - 1) @(negedge CLOCK_50);
            checks++;
            if (obs !== s.want) begin errors++; $display("FAIL %s got %h want %h", s.tag, obs, s.want); end
        end
        push("asyncRst", P_NONE, 0, 0, 0, 0, 0, 3'b000);
        #2 resetn = 1'b0;
        #1;
        s = sbQ.pop_front();
        checks++;
        if (obs !== s.want) begin errors++; $display("FAIL %s got %h want %h", s.tag, obs, s.want); end
        @(negedge CLOCK_50);
        resetn = 1'b1;
        push("postRst",   P_NONE,  1, 0, 0, 0, 0, 3'b000);
        push("startZero", P_START, 1, 0, 0, 0, 0, 3'b000);
        push("noResidue", P_NONE,  5, 0, 0, 0, 0, 3'b000);
        while (sbQ.size() != 0) begin
            s = sbQ.pop_front();
            {bus.stop_pulse, bus.load_pulse, bus.start_pulse} = s.pul;
            @(negedge CLOCK_50);
            {bus.stop_pulse, bus.load_pulse, bus.start_pulse} = P_NONE;
            repeat (s.cycles - 1) @(negedge CLOCK_50);
            checks++;
            if (obs !== s.want) begin errors++; $display("FAIL %s got %h want %h", s.tag, obs, s.want); end
        end
    endtask

    task automatic test_first_edge;
        step_t s;
        resetn = 1'b0;
        setPreset(0, 0, 2, 0);
        bus.load_pulse = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        resetn = 1'b1;
        push("heldLoad", P_NONE, 0, 0, 0, 0, 0, 3'b000);
        @(negedge CLOCK_50);
        bus.load_pulse = 1'b0;
        s = sbQ.pop_front();
        checks++;
        if (obs !== s.want) begin errors++; $display("FAIL %s got %h want %h", s.tag, obs, s.want); end
        push("freshLoad", P_LOAD, 1, 0, 0, 2, 0, 3'b000);
        push("clr3",      P_STOP, 1, 0, 0, 0, 0, 3'b000);
        while (sbQ.size() != 0) begin
            s = sbQ.pop_front();
            {bus.stop_pulse, bus.load_pulse, bus.start_pulse} = s.pul;
            @(negedge CLOCK_50);
            {bus.stop_pulse, bus.load_pulse, bus.start_pulse} = P_NONE;
            repeat (s.cycles - 1) @(negedge CLOCK_50);
            checks++;
            if (obs !== s.want) begin errors++; $display("FAIL %s got %h want %h", s.tag, obs, s.want); end
        end
    endtask

    initial begin
        resetn = 1'b1;
        {bus.stop_pulse, bus.load_pulse, bus.start_pulse} = P_NONE;
        setPreset(0, 0, 0, 0);
        #1 resetn = 1'b0;
        test_reset();
        test_load();
        test_blink();
        test_borrow();
        test_pause_resume();
        test_clamp_priority();
        test_done_load();
        test_reset_midrun();
        test_first_edge();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
